// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an iterative shift-add multiplier.
//
// state | meaning
// IDLE  | accepting start; single-cycle ops complete on the start edge
// MUL   | shift-add multiply running, one partial product per clock
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, op       operation request (sampled only while busy=0) and opcode
//   a, b            operands; b[SHW-1:0] is the shift amount for shifts
//   set_flags       update NZCV when this operation completes
//   busy            multiply in progress, start ignored
//   done            one-cycle pulse, y/flags valid
//   y, flags        registered result and {N,Z,C,V}
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_ORR  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_EOR  = 4'h4;
  localparam logic [3:0] OP_BIC  = 4'h5;
  localparam logic [3:0] OP_LSL  = 4'h6;
  localparam logic [3:0] OP_LSR  = 4'h7;
  localparam logic [3:0] OP_ASR  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             v_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic [WIDTH-1:0] res;
  logic             c_new, v_new, c_upd, v_upd, nop;

  logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
  logic [SHW-1:0]   cnt;
  logic             mul_sf, last;

  // SLT/SLTU reuse the subtractor so they never depend on the flag register.
  always_comb begin
    sub     = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    b_eff   = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    v_sum   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    shamt   = b[SHW-1:0];
    // One extra bit on each shifter catches the last bit shifted out.
    lsl_ext = {1'b0, a} << shamt;
    lsr_ext = {a, 1'b0} >> shamt;
    asr_ext = $signed({a, 1'b0}) >>> shamt;
    res   = '0;
    c_new = 1'b0;
    v_new = 1'b0;
    c_upd = 1'b0;
    v_upd = 1'b0;
    nop   = (op >= 4'hC);
    case (op)
      OP_AND:  res = a & b;
      OP_ORR:  res = a | b;
      OP_EOR:  res = a ^ b;
      OP_BIC:  res = a & ~b;
      OP_ADD, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = v_sum;
        c_upd = 1'b1;
        v_upd = 1'b1;
      end
      OP_LSL: begin
        res   = lsl_ext[WIDTH-1:0];
        c_new = lsl_ext[WIDTH];
        c_upd = (shamt != '0);
      end
      OP_LSR: begin
        res   = lsr_ext[WIDTH:1];
        c_new = lsr_ext[0];
        c_upd = (shamt != '0);
      end
      OP_ASR: begin
        res   = asr_ext[WIDTH:1];
        c_new = asr_ext[0];
        c_upd = (shamt != '0);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v_sum};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      default: res = '0;
    endcase
  end

  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign last   = (cnt == '0);
  assign busy   = (state == MUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && op == OP_MUL) state_nx = MUL;
      MUL:     if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      y      <= '0;
      flags  <= 4'b0000;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_sf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            // Down-counter: terminal count 0 marks the WIDTH-th iteration.
            cnt    <= SHW'(WIDTH - 1);
            mul_sf <= set_flags;
          end else begin
            y    <= res;
            done <= 1'b1;
            if (set_flags && !nop)
              flags <= {res[WIDTH-1], res == '0,
                        c_upd ? c_new : flags[1],
                        v_upd ? v_new : flags[0]};
          end
        end
      end else begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (last) begin
          y    <= acc_nx;
          done <= 1'b1;
          if (mul_sf) flags[3:2] <= {acc_nx[WIDTH-1], acc_nx == '0};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        set_flags = 1'b0;
  logic        busy, done;
  logic [31:0] y;
  logic [3:0]  flags;

  exp_t        sbq[$];
  logic [3:0]  mflags = 4'b0000;
  int          total = 0;
  int          bad = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .set_flags(set_flags), .busy(busy), .done(done), .y(y), .flags(flags)
  );

  always #5 clk = ~clk;

  function automatic exp_t calc(input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] z, input logic sf,
                                input logic [3:0] fl);
    exp_t   e;
    logic [31:0] r;
    logic   c, v;
    longint s;
    int     sh;
    c  = fl[1];
    v  = fl[0];
    sh = int'(z[4:0]);
    r  = '0;
    case (o)
      4'h0: r = x & z;
      4'h1: r = x | z;
      4'h2: begin
        {c, r} = {1'b0, x} + {1'b0, z};
        s = longint'($signed(x)) + longint'($signed(z));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: begin
        r = x - z;
        c = (x >= z);
        s = longint'($signed(x)) - longint'($signed(z));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h4: r = x ^ z;
      4'h5: r = x & ~z;
      4'h6: begin r = x << sh; if (sh != 0) c = x[32-sh]; end
      4'h7: begin r = x >> sh; if (sh != 0) c = x[sh-1]; end
      4'h8: begin r = $signed(x) >>> sh; if (sh != 0) c = x[sh-1]; end
      4'h9: r = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      4'hA: r = (x < z) ? 32'd1 : 32'd0;
      4'hB: r = x * z;
      default: r = '0;
    endcase
    e.y = r;
    if (sf && o < 4'hC) begin
      if (o == 4'hB) e.f = {r[31], r == 0, fl[1], fl[0]};
      else           e.f = {r[31], r == 0, c, v};
    end else begin
      e.f = fl;
    end
    return e;
  endfunction

  // Drives one start pulse and pushes the model result; returns #1 after the start edge.
  task automatic drive(input logic [3:0] o, input logic [31:0] ia,
                       input logic [31:0] ib, input logic sf);
    exp_t e;
    @(negedge clk);
    op = o; a = ia; b = ib; set_flags = sf; start = 1'b1;
    e = calc(o, ia, ib, sf, mflags);
    mflags = e.f;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done; reports cycles waited after the start edge.
  task automatic collect(input int budget, output exp_t obs, output int lat,
                         output bit timeout);
    lat = 0;
    timeout = 1'b0;
    while (done !== 1'b1 && lat < budget) begin
      @(posedge clk);
      #1 lat++;
    end
    if (done !== 1'b1) timeout = 1'b1;
    obs.y = y;
    obs.f = flags;
  endtask

  task automatic pop_exp(output exp_t e, output bit empty);
    empty = (sbq.size() == 0);
    if (empty) e = '0;
    else       e = sbq.pop_front();
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (y !== 32'h0) begin bad++; $display("FAIL reset_y got=%h want=0", y); end
    total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_single(input string name);
    exp_t obs, e;
    int lat;
    bit to, empty;
    collect(4, obs, lat, to);
    pop_exp(e, empty);
    total++; if (to || lat != 0) begin bad++; $display("FAIL %s_latency got=%0d timeout=%0d want=0", name, lat, to); end
    total++; if (empty) begin bad++; $display("FAIL %s_queue got=empty want=entry", name); end
    total++; if (obs.y !== e.y) begin bad++; $display("FAIL %s_y got=%h want=%h", name, obs.y, e.y); end
    total++; if (obs.f !== e.f) begin bad++; $display("FAIL %s_flags got=%b want=%b", name, obs.f, e.f); end
  endtask

  task automatic test_add;
    drive(4'h2, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    check_single("add_ovf");
    total++; if (y !== 32'h80000000 || flags !== 4'b1001) begin bad++; $display("FAIL add_ovf_const got=%h/%b want=80000000/1001", y, flags); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_sub;
    drive(4'h3, 32'd5, 32'd5, 1'b1);
    check_single("sub_eq");
    total++; if (flags !== 4'b0110) begin bad++; $display("FAIL sub_eq_const got=%b want=0110", flags); end
    drive(4'h3, 32'd3, 32'd5, 1'b1);
    check_single("sub_borrow");
    total++; if (y !== 32'hFFFFFFFE || flags !== 4'b1000) begin bad++; $display("FAIL sub_borrow_const got=%h/%b want=fffffffe/1000", y, flags); end
  endtask

  task automatic test_compare;
    drive(4'h9, 32'hFFFFFFFF, 32'd1, 1'b1);
    check_single("slt");
    total++; if (y !== 32'd1 || flags !== 4'b0000) begin bad++; $display("FAIL slt_const got=%h/%b want=1/0000", y, flags); end
    drive(4'hA, 32'hFFFFFFFF, 32'd1, 1'b1);
    check_single("sltu");
    drive(4'h9, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    check_single("slt_ovf");
  endtask

  task automatic test_shift;
    drive(4'h8, 32'h80000000, 32'd4, 1'b1);
    check_single("asr");
    total++; if (y !== 32'hF8000000 || flags[1] !== 1'b0) begin bad++; $display("FAIL asr_const got=%h/%b want=f8000000/C=0", y, flags); end
    drive(4'h7, 32'h3, 32'd1, 1'b1);
    check_single("lsr");
    total++; if (y !== 32'd1 || flags[1] !== 1'b1) begin bad++; $display("FAIL lsr_const got=%h/%b want=1/C=1", y, flags); end
    drive(4'h6, 32'h12345678, 32'h20, 1'b1);
    check_single("lsl_zero");
    total++; if (y !== 32'h12345678 || flags[1] !== 1'b1) begin bad++; $display("FAIL lsl_zero_const got=%h/%b want=12345678/C=1", y, flags); end
    drive(4'h6, 32'h80000001, 32'hFFFFFFE1, 1'b1);
    check_single("lsl_one");
  endtask

  task automatic test_nop;
    drive(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check_single("nop");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] o;
      o = (i % 4 == 3) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 10));
      drive(o, $urandom, (o >= 4'h6 && o <= 4'h8) ? 32'($urandom_range(0, 63)) : $urandom,
            1'($urandom_range(0, 1)));
      check_single($sformatf("rand%0d_op%0h", i, o));
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [4] = '{4'h2, 4'h4, 4'h3, 4'h6};
    exp_t e;
    bit empty;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 32'h0F0F0000 + 32'(i), 32'h00000003 + 32'(i), 1'b1);
      pop_exp(e, empty);
      total++; if (done !== 1'b1 || empty || y !== e.y || flags !== e.f) begin
        bad++; $display("FAIL b2b%0d got=%b/%h/%b want=1/%h/%b", i, done, y, flags, e.y, e.f);
      end
    end
  endtask

  task automatic test_mul;
    exp_t e, obs;
    bit empty, to;
    int busy_cnt, done_cnt, done_cyc, lat;
    drive(4'hB, 32'h00010003, 32'h00000005, 1'b1);
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    done_cnt = 0;
    done_cyc = -1;
    obs = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; obs.y = y; obs.f = flags; end
      if (cyc == 9) begin op = 4'h2; a = 32'd1; b = 32'd1; set_flags = 1'b1; start = 1'b1; end
      if (cyc == 10) start = 1'b0;
    end
    pop_exp(e, empty);
    total++; if (busy_cnt != 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", busy_cnt); end
    total++; if (done_cnt != 1 || done_cyc != 32) begin bad++; $display("FAIL mul_done got=%0d@%0d want=1@32", done_cnt, done_cyc); end
    total++; if (empty || obs.y !== e.y || obs.f !== e.f) begin bad++; $display("FAIL mul_result got=%h/%b want=%h/%b", obs.y, obs.f, e.y, e.f); end
    total++; if (obs.y !== 32'h0005000F) begin bad++; $display("FAIL mul_const got=%h want=0005000f", obs.y); end
    drive(4'hB, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
    collect(40, obs, lat, to);
    pop_exp(e, empty);
    total++; if (to || lat != 32 || empty || obs.y !== e.y || obs.f !== e.f) begin
      bad++; $display("FAIL mul_neg got=%h/%b lat=%0d want=%h/%b lat=32", obs.y, obs.f, lat, e.y, e.f);
    end
  endtask

  task automatic test_reset_mid;
    drive(4'h3, 32'd5, 32'd5, 1'b1);
    check_single("pre_reset");
    drive(4'hB, 32'h00010003, 32'h5, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || y !== 32'h0 || flags !== 4'b0000) begin
      bad++; $display("FAIL mid_reset got=%b/%b/%h/%b want=0/0/0/0000", busy, done, y, flags);
    end
    sbq.delete();
    mflags = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_stray_done got=%b want=0", done); end
    end
    drive(4'h2, 32'h00000010, 32'h00000020, 1'b0);
    check_single("post_reset_add");
    total++; if (y !== 32'h30 || flags !== 4'b0000) begin bad++; $display("FAIL post_reset_const got=%h/%b want=30/0000", y, flags); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_shift();
    test_nop();
    test_random();
    test_back_to_back();
    test_mul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
